pmp_unit: RTL and testbench

//  Parametrised N-entry physical memory protection unit: pmpcfg/pmpaddr CSR file plus a pipelined

---
 rtl/cep_define.sv | 40 ++++
 rtl/pmp_entry_match.sv | 46 ++++
 rtl/pmp_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_pmp_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cep_define.sv
// Shared PMP definitions: address-matching modes, the pmpcfg byte layout,
// access kinds and the CSR address map.
package cep_define;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_mode_t;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_mode_t  a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        ACC_R = 2'd0,
        ACC_W = 2'd1,
        ACC_X = 2'd2
    } access_t;

    localparam logic [11:0] PMPCFG0  = 12'h3A0;
    localparam logic [11:0] PMPADDR0 = 12'h3B0;
    localparam int          PMP_MAX  = 16;

    // Reserved bits read as zero, and W is only kept when R is also set.
    function automatic pmpcfg_t pmpcfg_legalize(input logic [7:0] wbyte);
        pmpcfg_t c;
        c      = pmpcfg_t'(wbyte);
        c.rsvd = 2'b00;
        c.w    = wbyte[1] & wbyte[0];
        return c;
    endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Region test for one PMP entry: reports whether the first and last byte of
// an access fall inside the entry's region (full) or only one of them does (partial).
module pmp_entry_match
    import cep_define::*;
(
    input  logic [31:0] first_word,
    input  logic [31:0] last_word,
    input  logic [31:0] pmpaddr,
    input  logic [31:0] pmpaddr_prev,
    input  pmp_mode_t   mode,
    output logic        full,
    output logic        partial
);

    logic [31:0] napot_mask;
    logic        first_in;
    logic        last_in;

    // Words are compared as a[33:2]; the top two bits of a 32-bit request
    // address are zero, so no comparison ever wraps.
    function automatic logic region_hit(
        input logic [31:0] w,
        input pmp_mode_t   m,
        input logic [31:0] top,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        case (m)
            TOR:     return (w >= base) && (w < top);
            NA4:     return w == top;
            NAPOT:   return ((w ^ top) & mask) == 32'd0;
            default: return 1'b0;
        endcase
    endfunction

    // Flipping the trailing ones plus the next zero exposes the ignored low bits;
    // an all-ones pmpaddr yields a zero mask and so covers every address.
    assign napot_mask = ~(pmpaddr ^ (pmpaddr + 32'd1));

    assign first_in = region_hit(first_word, mode, pmpaddr, pmpaddr_prev, napot_mask);
    assign last_in  = region_hit(last_word,  mode, pmpaddr, pmpaddr_prev, napot_mask);

    assign full    = first_in & last_in;
    assign partial = first_in ^ last_in;

endmodule

// File: rtl/pmp_unit.sv
// Physical memory protection unit: pmpcfg/pmpaddr CSR file plus a two-stage
// access checker (S1 = region match, S2 = priority pick and permission decision).
module pmp_unit
    import cep_define::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int ENTRY_W   = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    input  logic [1:0]         req_size,
    input  logic [1:0]         req_type,
    input  logic               req_priv_m,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_fault,
    output logic               resp_hit,
    output logic [ENTRY_W-1:0] resp_entry
);

    pmpcfg_t     cfg_q  [PMP_MAX];
    logic [31:0] addr_q [PMP_MAX];

    // CSR file; unimplemented entries are constant zero and swallow writes.
    for (genvar gi = 0; gi < PMP_MAX; gi++) begin : g_csr
        if (gi < N_ENTRIES) begin : g_impl
            pmpcfg_t     cfg_reg;
            logic [31:0] addr_reg;
            logic        cfg_sel;
            logic        addr_sel;
            logic        addr_locked;

            assign cfg_sel  = csr_we && (csr_addr == PMPCFG0 + 12'(gi / 4));
            assign addr_sel = csr_we && (csr_addr == PMPADDR0 + 12'(gi));

            // A locked TOR entry above also freezes this entry's address, since it is that entry's base.
            if (gi + 1 < N_ENTRIES) begin : g_next
                assign addr_locked = cfg_reg.l || (cfg_q[gi+1].l && (cfg_q[gi+1].a == TOR));
            end else begin : g_last
                assign addr_locked = cfg_reg.l;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cfg_reg  <= '0;
                    addr_reg <= '0;
                end else begin
                    if (cfg_sel && !cfg_reg.l) begin
                        cfg_reg <= pmpcfg_legalize(csr_wdata[8*(gi%4) +: 8]);
                    end
                    if (addr_sel && !addr_locked) begin
                        addr_reg <= csr_wdata;
                    end
                end
            end

            assign cfg_q[gi]  = cfg_reg;
            assign addr_q[gi] = addr_reg;
        end else begin : g_none
            assign cfg_q[gi]  = '0;
            assign addr_q[gi] = '0;
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_addr[11:2] == PMPCFG0[11:2]) begin
            for (int j = 0; j < 4; j++) begin
                csr_rdata[8*j +: 8] = cfg_q[{csr_addr[1:0], 2'(j)}];
            end
        end else if (csr_addr[11:4] == PMPADDR0[11:4]) begin
            csr_rdata = addr_q[csr_addr[3:0]];
        end
    end

    // Handshake: each stage moves when the stage after it can take its contents.
    logic s1_valid_reg;
    logic resp_valid_reg;
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv    = !resp_valid_reg || resp_ready;
    assign s1_adv    = !s1_valid_reg || s2_adv;
    assign req_ready = s1_adv;
    assign accept    = req_valid && s1_adv;

    logic [2:0]  size_m1;
    logic        last_carry;
    logic [31:0] first_word;
    logic [31:0] last_word;

    always_comb begin
        case (req_size)
            2'd0:    size_m1 = 3'd0;
            2'd1:    size_m1 = 3'd1;
            default: size_m1 = 3'd3;
        endcase
    end

    assign last_carry = ({1'b0, req_addr[1:0]} + size_m1) > 3'd3;
    assign first_word = {2'b00, req_addr[31:2]};
    assign last_word  = first_word + {31'd0, last_carry};

    logic [N_ENTRIES-1:0] match_full;
    logic [N_ENTRIES-1:0] match_partial;
    logic [N_ENTRIES-1:0] cfg_l;
    logic [N_ENTRIES-1:0] cfg_r;
    logic [N_ENTRIES-1:0] cfg_w;
    logic [N_ENTRIES-1:0] cfg_x;

    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_match
        logic [31:0] prev_addr;

        if (gi == 0) begin : g_base0
            assign prev_addr = '0;
        end else begin : g_basen
            assign prev_addr = addr_q[gi-1];
        end

        pmp_entry_match u_match (
            .first_word   (first_word),
            .last_word    (last_word),
            .pmpaddr      (addr_q[gi]),
            .pmpaddr_prev (prev_addr),
            .mode         (cfg_q[gi].a),
            .full         (match_full[gi]),
            .partial      (match_partial[gi])
        );

        assign cfg_l[gi] = cfg_q[gi].l;
        assign cfg_r[gi] = cfg_q[gi].r;
        assign cfg_w[gi] = cfg_q[gi].w;
        assign cfg_x[gi] = cfg_q[gi].x;
    end

    // S1 snapshots the permission bits too, so a CSR write landing behind an
    // accepted request cannot change that request's decision.
    logic [N_ENTRIES-1:0] s1_full_reg;
    logic [N_ENTRIES-1:0] s1_partial_reg;
    logic [N_ENTRIES-1:0] s1_l_reg;
    logic [N_ENTRIES-1:0] s1_r_reg;
    logic [N_ENTRIES-1:0] s1_w_reg;
    logic [N_ENTRIES-1:0] s1_x_reg;
    logic [1:0]           s1_type_reg;
    logic                 s1_priv_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_full_reg    <= '0;
            s1_partial_reg <= '0;
            s1_l_reg       <= '0;
            s1_r_reg       <= '0;
            s1_w_reg       <= '0;
            s1_x_reg       <= '0;
            s1_type_reg    <= '0;
            s1_priv_reg    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_full_reg    <= match_full;
                s1_partial_reg <= match_partial;
                s1_l_reg       <= cfg_l;
                s1_r_reg       <= cfg_r;
                s1_w_reg       <= cfg_w;
                s1_x_reg       <= cfg_x;
                s1_type_reg    <= req_type;
                s1_priv_reg    <= req_priv_m;
            end
        end
    end

    logic [N_ENTRIES-1:0] hit_vec;
    logic [ENTRY_W-1:0]   win_entry_next;
    logic                 win_partial;
    logic                 win_lock;
    logic                 win_perm;
    logic                 fault_next;
    logic                 hit_next;

    assign hit_vec  = s1_full_reg | s1_partial_reg;
    assign hit_next = |hit_vec;

    // Scanning downward leaves the lowest-numbered matching entry as the winner.
    always_comb begin
        win_entry_next = '0;
        win_partial    = 1'b0;
        win_lock       = 1'b0;
        win_perm       = 1'b0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_entry_next = ENTRY_W'(i);
                win_partial    = s1_partial_reg[i];
                win_lock       = s1_l_reg[i];
                case (s1_type_reg)
                    ACC_W:   win_perm = s1_w_reg[i];
                    ACC_X:   win_perm = s1_x_reg[i];
                    default: win_perm = s1_r_reg[i];
                endcase
            end
        end
    end

    always_comb begin
        if (!hit_next) begin
            fault_next = !s1_priv_reg;
        end else if (win_partial) begin
            fault_next = 1'b1;
        end else if (s1_priv_reg && !win_lock) begin
            fault_next = 1'b0;
        end else begin
            fault_next = !win_perm;
        end
    end

    logic               resp_fault_reg;
    logic               resp_hit_reg;
    logic [ENTRY_W-1:0] resp_entry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_fault_reg <= 1'b0;
            resp_hit_reg   <= 1'b0;
            resp_entry_reg <= '0;
        end else if (s2_adv) begin
            resp_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                resp_fault_reg <= fault_next;
                resp_hit_reg   <= hit_next;
                resp_entry_reg <= win_entry_next;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_fault = resp_fault_reg;
    assign resp_hit   = resp_hit_reg;
    assign resp_entry = resp_entry_reg;

endmodule

// File: tb/tb_pmp_unit.sv
// Directed bench for pmp_unit: expected responses are queued on acceptance and
// checked against every cycle a response is presented.
module tb_pmp_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [1:0]  req_type;
    logic        req_priv_m;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_fault;
    logic        resp_hit;
    logic [2:0]  resp_entry;

    pmp_unit #(.N_ENTRIES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_type   (req_type),
        .req_priv_m (req_priv_m),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_fault (resp_fault),
        .resp_hit   (resp_hit),
        .resp_entry (resp_entry)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fault;
        logic       hit;
        logic [2:0] entry;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic f, input logic h, input logic [2:0] e);
        exp_t x;
        x.fault = f;
        x.hit   = h;
        x.entry = e;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: held or fresh, every presented response must equal the queue head.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
            end else begin
                chk("resp_fault", {31'd0, resp_fault}, {31'd0, sb[0].fault});
                chk("resp_hit",   {31'd0, resp_hit},   {31'd0, sb[0].hit});
                chk("resp_entry", {29'd0, resp_entry}, {29'd0, sb[0].entry});
                $display("resp fault=%0d hit=%0d entry=%0d ready=%0d", resp_fault, resp_hit, resp_entry, resp_ready);
                if (resp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        $display("csr write addr=0x%0h data=0x%0h", a, d);
    endtask

    task automatic csr_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
        $display("csr read addr=0x%0h data=0x%0h", a, csr_rdata);
    endtask

    task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                        input logic pm, input exp_t e);
        int n = 0;
        bit ok = 1'b0;
        req_valid  = 1'b1;
        req_addr   = a;
        req_size   = sz;
        req_type   = ty;
        req_priv_m = pm;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        chk("req_accept", {31'd0, ok}, 32'd1);
        $display("req addr=0x%0h size=%0d type=%0d m=%0d exp fault=%0d hit=%0d entry=%0d",
                 a, sz, ty, pm, e.fault, e.hit, e.entry);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    logic [31:0] bp_addr [4] = '{32'h1000, 32'h1004, 32'h0, 32'h1FFE};
    logic [1:0]  bp_size [4] = '{2'd2, 2'd2, 2'd2, 2'd1};
    logic [1:0]  bp_type [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic        bp_priv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int acc;
        int cyc;
        exp_t bp_exp [4];
        bp_exp[0] = mk(1'b0, 1'b1, 3'd1);
        bp_exp[1] = mk(1'b1, 1'b1, 3'd1);
        bp_exp[2] = mk(1'b0, 1'b0, 3'd0);
        bp_exp[3] = mk(1'b1, 1'b1, 3'd1);

        rst = 1'b1; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_type = '0; req_priv_m = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_resp_hit",   {31'd0, resp_hit},   32'd0);
        chk("rst_resp_entry", {29'd0, resp_entry}, 32'd0);
        csr_chk("rst_cfg0",  12'h3A0, 32'h0);
        csr_chk("rst_addr0", 12'h3B0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // No entries: U-mode denied, M-mode allowed; two-cycle latency
        send(32'h1000, 2'd2, 2'd0, 1'b0, mk(1'b1, 1'b0, 3'd0));
        @(negedge clk);
        chk("latency_t1", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("latency_t2", {31'd0, resp_valid}, 32'd1);
        @(posedge clk);
        #1;
        send(32'h1000, 2'd2, 2'd0, 1'b1, mk(1'b0, 1'b0, 3'd0));
        drain();

        // TOR [0,0x1000) R, plus WARL legalisation of entries 2 and 3
        csr_wr(12'h3B0, 32'h400);
        csr_wr(12'h3A0, 32'h026B0009);
        csr_chk("cfg_warl", 12'h3A0, 32'h000B0009);
        csr_chk("addr0_rb", 12'h3B0, 32'h400);
        send(32'hFFC,  2'd2, 2'd0, 1'b0, mk(1'b0, 1'b1, 3'd0));
        send(32'hFFC,  2'd2, 2'd1, 1'b0, mk(1'b1, 1'b1, 3'd0));
        send(32'hFFE,  2'd2, 2'd0, 1'b0, mk(1'b1, 1'b1, 3'd0));
        send(32'h1000, 2'd0, 2'd0, 1'b0, mk(1'b1, 1'b0, 3'd0));
        drain();

        // NA4 at 0x400 (R|W) ahead of NAPOT 0..0xFFF (X)
        csr_wr(12'h3B1, 32'h1FF);
        csr_wr(12'h3B0, 32'h100);
        csr_wr(12'h3A0, 32'h000B1C13);
        csr_chk("cfg_na4_napot", 12'h3A0, 32'h000B1C13);
        send(32'h400,  2'd2, 2'd2, 1'b0, mk(1'b1, 1'b1, 3'd0));
        send(32'h404,  2'd2, 2'd2, 1'b0, mk(1'b0, 1'b1, 3'd1));
        send(32'h400,  2'd2, 2'd2, 1'b1, mk(1'b0, 1'b1, 3'd0));
        send(32'hFFF,  2'd1, 2'd2, 1'b0, mk(1'b1, 1'b1, 3'd1));
        send(32'h1000, 2'd2, 2'd2, 1'b0, mk(1'b1, 1'b0, 3'd0));
        drain();

        // Locked entry 0 binds M-mode and freezes its own CSRs
        csr_wr(12'h3B0, 32'h400);
        csr_wr(12'h3A0, 32'h000B1C89);
        send(32'h10, 2'd2, 2'd1, 1'b1, mk(1'b1, 1'b1, 3'd0));
        send(32'h10, 2'd2, 2'd0, 1'b1, mk(1'b0, 1'b1, 3'd0));
        csr_wr(12'h3B0, 32'h0);
        csr_chk("locked_addr0", 12'h3B0, 32'h400);
        csr_wr(12'h3A0, 32'h000B1D00);
        csr_chk("locked_cfg0", 12'h3A0, 32'h000B1D89);
        send(32'h10, 2'd2, 2'd2, 1'b0, mk(1'b1, 1'b1, 3'd0));
        drain();

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        csr_chk("lock_cleared", 12'h3A0, 32'h0);

        // Locked TOR entry 1 also freezes pmpaddr0, its base
        csr_wr(12'h3B0, 32'h400);
        csr_wr(12'h3B1, 32'h800);
        csr_wr(12'h3A0, 32'h00008900);
        csr_wr(12'h3B0, 32'h123);
        csr_chk("tor_lock_addr0", 12'h3B0, 32'h400);
        csr_wr(12'h3B1, 32'h555);
        csr_chk("tor_lock_addr1", 12'h3B1, 32'h800);
        csr_wr(12'h3B2, 32'h77);
        csr_chk("free_addr2", 12'h3B2, 32'h77);
        csr_wr(12'h3B8, 32'hFFFF);
        csr_chk("unimpl_addr8", 12'h3B8, 32'h0);
        csr_chk("unimpl_cfg2",  12'h3A2, 32'h0);
        csr_chk("unmapped",     12'h3A4, 32'h0);

        // Backpressure: responses stalled for the first 5 cycles
        acc = 0;
        cyc = 0;
        while ((acc < 4 || sb.size() != 0) && cyc < 40) begin
            resp_ready = (cyc >= 5);
            if (acc < 4) begin
                req_valid  = 1'b1;
                req_addr   = bp_addr[acc];
                req_size   = bp_size[acc];
                req_type   = bp_type[acc];
                req_priv_m = bp_priv[acc];
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 2) begin
                chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
                chk("bp_accepted",  acc,                32'd2);
            end
            if (req_valid && req_ready) begin
                sb.push_back(bp_exp[acc]);
                $display("bp req %0d accepted in cycle %0d", acc, cyc);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        chk("bp_all_accepted", acc, 32'd4);
        drain();

        // CSR write in the same cycle as a request: the request sees the old config
        csr_we     = 1'b1;
        csr_addr   = 12'h3A0;
        csr_wdata  = 32'h00000009;
        req_valid  = 1'b1;
        req_addr   = 32'h100;
        req_size   = 2'd2;
        req_type   = 2'd0;
        req_priv_m = 1'b0;
        @(negedge clk);
        chk("same_cycle_ready", {31'd0, req_ready}, 32'd1);
        if (req_ready) sb.push_back(mk(1'b1, 1'b0, 3'd0));
        @(posedge clk);
        #1;
        csr_we    = 1'b0;
        req_valid = 1'b0;
        send(32'h100, 2'd2, 2'd0, 1'b0, mk(1'b0, 1'b1, 3'd0));
        csr_chk("cfg_after_same", 12'h3A0, 32'h00008909);
        drain();

        // Reset with both stages occupied drops everything
        resp_ready = 1'b0;
        send(32'h100, 2'd2, 2'd0, 1'b0, mk(1'b0, 1'b1, 3'd0));
        send(32'h104, 2'd2, 2'd0, 1'b0, mk(1'b0, 1'b1, 3'd0));
        rst = 1'b1;
        @(negedge clk);
        chk("full_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("full_req_ready",  {31'd0, req_ready},  32'd0);
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(32'h0, 2'd2, 2'd0, 1'b0, mk(1'b1, 1'b0, 3'd0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
